// File: rtl/mem_port_arbiter.sv
// Fetch/data arbiter for the shared single-ported instruction/data memory.
// Optional fetch starvation guard: define ARB_STARVE_GUARD_EN.
module mem_port_arbiter #(
  parameter int WAIT_CYCLES  = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        IReqF,
  input  logic [31:0] IAddrF,
  output logic [31:0] IRdataF,
  output logic        IAckF,
  input  logic        DReqM,
  input  logic        DWeM,
  input  logic [31:0] DAddrM,
  input  logic [31:0] DWdataM,
  output logic [31:0] DRdataM,
  output logic        DAckM,
  output logic        MemReq,
  output logic        MemWe,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWdata,
  input  logic [31:0] MemRdata,
  output logic        StallF,
  output logic        StallM,
  output logic        OwnerD
);

  if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15 ||
      STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : gBadParam
    $error("mem_port_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  localparam logic [3:0] CntInit = 4'(WAIT_CYCLES - 1);

  state_t     state;
  logic [3:0] cnt;
  logic       grantI;
  logic       grantD;

`ifdef ARB_STARVE_GUARD_EN
  localparam logic [3:0] StarveMax = 4'(STARVE_LIMIT);

  logic [3:0] streak;
  logic       starveHit;

  assign starveHit = streak >= StarveMax;
  assign grantI    = IReqF & (~DReqM | starveHit);

  // Counts data grants that left a waiting fetch behind.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      streak <= '0;
    end else if (state == IDLE) begin
      if (grantI) begin
        streak <= '0;
      end else if (grantD && IReqF && streak < StarveMax) begin
        streak <= streak + 4'd1;
      end
    end
  end
`else
  assign grantI = IReqF & ~DReqM;
`endif

  assign grantD = DReqM & ~grantI;
  assign StallF = IReqF & ~IAckF;
  assign StallM = DReqM & ~DAckM;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      OwnerD   <= 1'b0;
      MemReq   <= 1'b0;
      MemWe    <= 1'b0;
      MemAddr  <= '0;
      MemWdata <= '0;
      IRdataF  <= '0;
      DRdataM  <= '0;
      IAckF    <= 1'b0;
      DAckM    <= 1'b0;
    end else begin
      IAckF <= 1'b0;
      DAckM <= 1'b0;
      unique case (state)
        IDLE: begin
          if (grantI || grantD) begin
            state    <= BUSY;
            cnt      <= CntInit;
            OwnerD   <= grantD;
            MemReq   <= 1'b1;
            MemWe    <= grantD & DWeM;
            MemAddr  <= grantD ? DAddrM : IAddrF;
            MemWdata <= grantD ? DWdataM : '0;
          end
        end
        BUSY: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            state  <= RESP;
            MemReq <= 1'b0;
            MemWe  <= 1'b0;
            if (OwnerD) begin
              DAckM <= 1'b1;
              if (!MemWe) DRdataM <= MemRdata;
            end else begin
              IAckF   <= 1'b1;
              IRdataF <= MemRdata;
            end
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (WAIT_CYCLES=2 main, 1 second).
// Honours ARB_STARVE_GUARD_EN for the expected grant order.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        IReqF = 1'b0;
  logic [31:0] IAddrF = '0;
  logic        DReqM = 1'b0;
  logic        DWeM = 1'b0;
  logic [31:0] DAddrM = '0;
  logic [31:0] DWdataM = '0;

  logic [31:0] IRdataF, DRdataM, MemAddr, MemWdata, MemRdata;
  logic        IAckF, DAckM, MemReq, MemWe, StallF, StallM, OwnerD;

  logic [31:0] IRdataF1, DRdataM1, MemAddr1, MemWdata1, MemRdata1;
  logic        IAckF1, DAckM1, MemReq1, MemWe1, StallF1, StallM1, OwnerD1;

  int passCnt = 0;
  int totalCnt = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] memModel(input logic [31:0] a);
    case (a)
      32'h10:  return 32'h0013_0093;
      32'h100: return 32'h1111_1111;
      32'h104: return 32'h2222_2222;
      default: return ~a;
    endcase
  endfunction

  assign MemRdata  = memModel(MemAddr);
  assign MemRdata1 = memModel(MemAddr1);

  mem_port_arbiter #(.WAIT_CYCLES(2), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .IReqF(IReqF), .IAddrF(IAddrF), .IRdataF(IRdataF), .IAckF(IAckF),
    .DReqM(DReqM), .DWeM(DWeM), .DAddrM(DAddrM), .DWdataM(DWdataM),
    .DRdataM(DRdataM), .DAckM(DAckM),
    .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr),
    .MemWdata(MemWdata), .MemRdata(MemRdata),
    .StallF(StallF), .StallM(StallM), .OwnerD(OwnerD)
  );

  mem_port_arbiter #(.WAIT_CYCLES(1), .STARVE_LIMIT(4)) dut1 (
    .clk(clk), .rst(rst),
    .IReqF(IReqF), .IAddrF(IAddrF), .IRdataF(IRdataF1), .IAckF(IAckF1),
    .DReqM(DReqM), .DWeM(DWeM), .DAddrM(DAddrM), .DWdataM(DWdataM),
    .DRdataM(DRdataM1), .DAckM(DAckM1),
    .MemReq(MemReq1), .MemWe(MemWe1), .MemAddr(MemAddr1),
    .MemWdata(MemWdata1), .MemRdata(MemRdata1),
    .StallF(StallF1), .StallM(StallM1), .OwnerD(OwnerD1)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    totalCnt++;
    if (got === exp) passCnt++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs the main DUT until the requester's ack, checking the access shape.
  task automatic waitAck(input string tag, input bit useD,
                         input logic expWe, input logic [31:0] expAddr,
                         input logic [31:0] expWdata, input int expLat);
    int k;
    int busy;
    bit stable;
    bit stallOk;
    bit got;
    k = 0; busy = 0; stable = 1; stallOk = 1; got = 0;
    while (!got && k < 40) begin
      tick();
      k++;
      got = useD ? DAckM : IAckF;
      if (MemReq) begin
        busy++;
        if (MemWe !== expWe || MemAddr !== expAddr ||
            MemWdata !== expWdata) stable = 0;
      end
      if (!got && ((useD ? StallM : StallF) !== 1'b1)) stallOk = 0;
    end
    chk({tag, ".lat"}, k, expLat);
    chk({tag, ".busy"}, busy, 2);
    chk({tag, ".stable"}, {31'd0, stable}, 32'd1);
    chk({tag, ".stallWait"}, {31'd0, stallOk}, 32'd1);
    chk({tag, ".stallAck"}, {31'd0, useD ? StallM : StallF}, 32'd0);
    chk({tag, ".owner"}, {31'd0, OwnerD}, {31'd0, useD});
  endtask

  initial begin
    logic [5:0] seq;
    int nAck;
    bit stallDrop;
    bit anyAck;
    bit hold;
    int a1;
    int a2;

    repeat (2) tick();
    chk("rst.mem", {MemReq, MemWe, MemAddr[29:0]}, 32'd0);
    chk("rst.wdata", MemWdata, 32'd0);
    chk("rst.rdata", IRdataF | DRdataM, 32'd0);
    chk("rst.flags", {26'd0, IAckF, DAckM, OwnerD, StallF, StallM, 1'b0},
        32'd0);

    rst = 1'b1;
    IReqF = 1'b1; IAddrF = 32'h10;
    #1;
    chk("fetch.stallReq", {31'd0, StallF}, 32'd1);
    waitAck("fetch", 1'b0, 1'b0, 32'h10, 32'h0, 3);
    chk("fetch.rdata", IRdataF, 32'h0013_0093);
    IReqF = 1'b0;
    tick();
    chk("fetch.pulse", {31'd0, IAckF}, 32'd0);

    DReqM = 1'b1; DWeM = 1'b1; DAddrM = 32'h40; DWdataM = 32'hDEAD_BEEF;
    waitAck("store", 1'b1, 1'b1, 32'h40, 32'hDEAD_BEEF, 3);
    chk("store.rdata", DRdataM, 32'h0);
    DReqM = 1'b0; DWeM = 1'b0; DWdataM = '0;
    tick();
    chk("store.pulse", {31'd0, DAckM}, 32'd0);

    IReqF = 1'b1; IAddrF = 32'h10;
    DReqM = 1'b1; DAddrM = 32'h100;
    waitAck("both.d", 1'b1, 1'b0, 32'h100, 32'h0, 3);
    chk("both.stallF", {31'd0, StallF}, 32'd1);
    chk("both.drdata", DRdataM, 32'h1111_1111);
    DReqM = 1'b0;
    waitAck("both.i", 1'b0, 1'b0, 32'h10, 32'h0, 4);
    IReqF = 1'b0;
    tick();

    IReqF = 1'b1; DReqM = 1'b1;
    seq = '0; nAck = 0; stallDrop = 0;
    for (int k = 0; k < 100 && nAck < 6; k++) begin
      tick();
      if (!StallF) stallDrop = 1;
      if (IAckF || DAckM) begin
        seq = {seq[4:0], DAckM};
        nAck++;
      end
    end
    chk("starve.count", nAck, 6);
`ifdef ARB_STARVE_GUARD_EN
    chk("starve.order", {26'd0, seq}, 32'b111101);
    chk("starve.stallF", {31'd0, stallDrop}, 32'd1);
`else
    chk("starve.order", {26'd0, seq}, 32'b111111);
    chk("starve.stallF", {31'd0, stallDrop}, 32'd0);
`endif
    IReqF = 1'b0; DReqM = 1'b0;
    tick();

    IReqF = 1'b1; IAddrF = 32'h20;
    tick();
    chk("abort.busy", {31'd0, MemReq}, 32'd1);
    rst = 1'b0;
    #1;
    chk("abort.mem", {MemReq, MemWe, MemAddr[29:0]}, 32'd0);
    chk("abort.rdata", IRdataF | DRdataM, 32'd0);
    chk("abort.owner", {31'd0, OwnerD}, 32'd0);
    anyAck = 0;
    repeat (4) begin
      tick();
      if (IAckF || DAckM || MemReq) anyAck = 1;
    end
    chk("abort.quiet", {31'd0, anyAck}, 32'd0);
    rst = 1'b1; IAddrF = 32'h10;
    waitAck("post", 1'b0, 1'b0, 32'h10, 32'h0, 3);
    chk("post.rdata", IRdataF, 32'h0013_0093);
    IReqF = 1'b0;
    repeat (5) tick();

    DReqM = 1'b1; DWeM = 1'b0; DAddrM = 32'h100;
    nAck = 0; a1 = 0; a2 = 0; hold = 1;
    for (int k = 1; k <= 20 && nAck < 2; k++) begin
      tick();
      if (DAckM1) begin
        nAck++;
        if (nAck == 1) begin
          a1 = k;
          chk("w1.first", DRdataM1, 32'h1111_1111);
          DAddrM = 32'h104;
        end else begin
          a2 = k;
          chk("w1.second", DRdataM1, 32'h2222_2222);
        end
      end else if (nAck == 1 && DRdataM1 !== 32'h1111_1111) begin
        hold = 0;
      end
    end
    chk("w1.lat", a1, 2);
    chk("w1.gap", a2 - a1, 3);
    chk("w1.hold", {31'd0, hold}, 32'd1);
    DReqM = 1'b0;
    tick();

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
